// File: rtl/dmem_resp.sv
// Data-side memory responder: direct-mapped write-through read-allocate word cache
// with a one-entry posted write buffer and a req/ack backing-memory port.
module dmem_resp #(
    parameter int          LINES     = 16,
    parameter logic [31:0] SEG_BASE  = 32'h0000_1000,
    parameter logic [31:0] SEG_LIMIT = 32'h0000_FFFC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wr_data,
    input  logic        d_rd,
    input  logic        d_wr,
    output logic [31:0] d_rd_data,
    output logic        d_miss,
    output logic        d_segfault,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack
);

    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = 32 - IDX_W - 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_FILL  = 2'd2
    } state_t;

    state_t             state_q;
    logic               valid_q [LINES];
    logic [TAG_W-1:0]   tag_q   [LINES];
    logic [31:0]        data_q  [LINES];
    logic [31:0]        d_rd_data_q;
    // While in DRAIN these two registers are the posted write buffer;
    // while in FILL mem_addr_q remembers which line the fill installs.
    logic               mem_req_q;
    logic               mem_we_q;
    logic [31:0]        mem_addr_q;
    logic [31:0]        mem_wdata_q;

    logic [IDX_W-1:0]   idx_s;
    logic [TAG_W-1:0]   tag_s;
    logic [IDX_W-1:0]   fill_idx_s;
    logic [TAG_W-1:0]   fill_tag_s;
    logic               seg_s;
    logic               hit_s;
    logic               load_acc_s;
    logic               load_miss_s;
    logic               store_acc_s;
    logic               store_miss_s;
    logic               start_fill_s;
    logic               fill_done_s;

    assign idx_s      = d_addr[IDX_W+1:2];
    assign tag_s      = d_addr[31:IDX_W+2];
    assign fill_idx_s = mem_addr_q[IDX_W+1:2];
    assign fill_tag_s = mem_addr_q[31:IDX_W+2];

    // Request classification: legality, hit/miss, and which transitions it triggers.
    always_comb begin
        seg_s        = 1'b0;
        hit_s        = 1'b0;
        load_acc_s   = 1'b0;
        load_miss_s  = 1'b0;
        store_acc_s  = 1'b0;
        store_miss_s = 1'b0;
        start_fill_s = 1'b0;
        fill_done_s  = 1'b0;
        if ((d_rd || d_wr) &&
            ((d_addr < SEG_BASE) || (d_addr > SEG_LIMIT) ||
             (d_addr[1:0] != 2'b00) || (d_rd && d_wr))) begin
            seg_s = 1'b1;
        end else begin
            seg_s = 1'b0;
        end
        hit_s        = valid_q[idx_s] && (tag_q[idx_s] == tag_s);
        load_acc_s   = d_rd && !seg_s && hit_s;
        load_miss_s  = d_rd && !seg_s && !hit_s;
        store_acc_s  = d_wr && !seg_s && (state_q == ST_IDLE);
        store_miss_s = d_wr && !seg_s && (state_q != ST_IDLE);
        start_fill_s = load_miss_s && (state_q == ST_IDLE);
        fill_done_s  = (state_q == ST_FILL) && mem_ack;
    end

    assign d_miss     = load_miss_s || store_miss_s;
    assign d_segfault = seg_s;

    // Transaction FSM: launches fills/drains and holds the memory port stable until ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'h0000_0000;
            mem_wdata_q <= 32'h0000_0000;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_fill_s) begin
                        state_q    <= ST_FILL;
                        mem_req_q  <= 1'b1;
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= {d_addr[31:2], 2'b00};
                    end else if (store_acc_s) begin
                        state_q     <= ST_DRAIN;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= {d_addr[31:2], 2'b00};
                        mem_wdata_q <= d_wr_data;
                    end
                end
                ST_DRAIN: begin
                    if (mem_ack) begin
                        state_q   <= ST_IDLE;
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                    end
                end
                ST_FILL: begin
                    if (mem_ack) begin
                        state_q   <= ST_IDLE;
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    mem_req_q <= 1'b0;
                    mem_we_q  <= 1'b0;
                end
            endcase
        end
    end

    // Cache array: fills install a whole line; stores only update a resident line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LINES; i++) begin
                valid_q[i] <= 1'b0;
                tag_q[i]   <= '0;
                data_q[i]  <= 32'h0000_0000;
            end
        end else if (fill_done_s) begin
            valid_q[fill_idx_s] <= 1'b1;
            tag_q[fill_idx_s]   <= fill_tag_s;
            data_q[fill_idx_s]  <= mem_rdata;
        end else if (store_acc_s && hit_s) begin
            data_q[idx_s] <= d_wr_data;
        end
    end

    // Load data register: zero after a segfault, line data after a hit, else hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_rd_data_q <= 32'h0000_0000;
        end else if (seg_s) begin
            d_rd_data_q <= 32'h0000_0000;
        end else if (load_acc_s) begin
            d_rd_data_q <= data_q[idx_s];
        end
    end

    assign d_rd_data = d_rd_data_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_dmem_resp.sv
// Directed testbench for dmem_resp with a queue scoreboard for load data.
module tb_dmem_resp;

    logic        clk;
    logic        rst_n;
    logic [31:0] d_addr;
    logic [31:0] d_wr_data;
    logic        d_rd;
    logic        d_wr;
    logic [31:0] d_rd_data;
    logic        d_miss;
    logic        d_segfault;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_q [$];

    dmem_resp dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .d_addr     (d_addr),
        .d_wr_data  (d_wr_data),
        .d_rd       (d_rd),
        .d_wr       (d_wr),
        .d_rd_data  (d_rd_data),
        .d_miss     (d_miss),
        .d_segfault (d_segfault),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] wd);
        d_rd = rd;
        d_wr = wr;
        d_addr = a;
        d_wr_data = wd;
        #1;
    endtask

    task automatic idle();
        d_rd = 1'b0;
        d_wr = 1'b0;
    endtask

    task automatic ack(input logic [31:0] rd);
        mem_ack = 1'b1;
        mem_rdata = rd;
        cyc();
        mem_ack = 1'b0;
        mem_rdata = 32'h0;
    endtask

    // Load expected to hit; expected data goes through the scoreboard queue.
    task automatic load_hit(input string tag, input logic [31:0] a, input logic [31:0] exp);
        drive(1'b1, 1'b0, a, 32'h0);
        chk({tag, "_miss"}, {31'h0, d_miss}, 32'h0);
        chk({tag, "_seg"}, {31'h0, d_segfault}, 32'h0);
        exp_q.push_back(exp);
        cyc();
        idle();
        chk({tag, "_data"}, d_rd_data, exp_q.pop_front());
    endtask

    // Load miss from IDLE, fill request check, acknowledge with data.
    task automatic fill(input string tag, input logic [31:0] a, input logic [31:0] rd);
        drive(1'b1, 1'b0, a, 32'h0);
        chk({tag, "_miss"}, {31'h0, d_miss}, 32'h1);
        cyc();
        idle();
        chk({tag, "_req"}, {30'h0, mem_req, mem_we}, 32'h2);
        chk({tag, "_addr"}, mem_addr, a);
        ack(rd);
        chk({tag, "_done"}, {31'h0, mem_req}, 32'h0);
    endtask

    logic [31:0] seg_addr [4];
    logic        seg_wr   [4];

    initial begin
        rst_n = 1'b0; mem_ack = 1'b0; mem_rdata = 32'h0;
        d_addr = 32'h0; d_wr_data = 32'h0; d_rd = 1'b0; d_wr = 1'b0;
        seg_addr[0] = 32'h0000_0FFC; seg_wr[0] = 1'b0;
        seg_addr[1] = 32'h0000_1002; seg_wr[1] = 1'b0;
        seg_addr[2] = 32'h0001_0000; seg_wr[2] = 1'b0;
        seg_addr[3] = 32'h0000_2000; seg_wr[3] = 1'b1;
        repeat (3) cyc();
        chk("rst_rdata", d_rd_data, 32'h0);
        chk("rst_memctl", {29'h0, mem_req, mem_we, d_miss}, 32'h0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_wdata", mem_wdata, 32'h0);
        rst_n = 1'b1;
        cyc();

        // Cold miss, replay during FILL, then hit.
        drive(1'b1, 1'b0, 32'h1000, 32'h0);
        chk("cold_miss", {31'h0, d_miss}, 32'h1);
        cyc();
        chk("cold_req", {30'h0, mem_req, mem_we}, 32'h2);
        chk("cold_addr", mem_addr, 32'h1000);
        #1;
        chk("fill_replay_miss", {31'h0, d_miss}, 32'h1);
        idle();
        ack(32'hDEAD_BEEF);
        chk("cold_done", {31'h0, mem_req}, 32'h0);
        load_hit("cold_hit", 32'h1000, 32'hDEAD_BEEF);
        cyc();
        chk("hold_rdata", d_rd_data, 32'hDEAD_BEEF);

        // Illegal accesses.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, seg_wr[i], seg_addr[i], 32'h1);
            chk("seg_flag", {30'h0, d_segfault, d_miss}, 32'h2);
            cyc();
            idle();
            chk("seg_noreq", {31'h0, mem_req}, 32'h0);
            chk("seg_rdata", d_rd_data, 32'h0);
        end

        // Top of the legal segment.
        fill("top_fill", 32'h0000_FFFC, 32'hA5A5_A5A5);
        load_hit("top_hit", 32'h0000_FFFC, 32'hA5A5_A5A5);

        // Store to resident line, immediate load, blocked second store.
        drive(1'b0, 1'b1, 32'h1000, 32'h1234_5678);
        chk("st_acc", {30'h0, d_miss, d_segfault}, 32'h0);
        cyc();
        idle();
        chk("st_req", {30'h0, mem_req, mem_we}, 32'h3);
        chk("st_addr", mem_addr, 32'h1000);
        chk("st_wdata", mem_wdata, 32'h1234_5678);
        load_hit("st_hit", 32'h1000, 32'h1234_5678);
        drive(1'b0, 1'b1, 32'h1040, 32'h9999_9999);
        chk("st2_miss", {31'h0, d_miss}, 32'h1);
        cyc();
        idle();
        chk("st2_addr", mem_addr, 32'h1000);
        chk("st2_wdata", mem_wdata, 32'h1234_5678);
        ack(32'h0);
        chk("st_done", {31'h0, mem_req}, 32'h0);

        // Store to non-resident address, then load it: no bypass of the drain.
        drive(1'b0, 1'b1, 32'h2000, 32'h0000_55AA);
        cyc();
        chk("nr_req", {30'h0, mem_req, mem_we}, 32'h3);
        drive(1'b1, 1'b0, 32'h2000, 32'h0);
        chk("nr_ld_miss", {31'h0, d_miss}, 32'h1);
        cyc();
        chk("nr_still_drain", {30'h0, mem_req, mem_we}, 32'h3);
        chk("nr_rdata_hold", d_rd_data, 32'h1234_5678);
        ack(32'h0);
        chk("nr_after_drain", {31'h0, mem_req}, 32'h0);
        idle();
        fill("nr_fill", 32'h2000, 32'h0000_55AA);
        load_hit("nr_hit", 32'h2000, 32'h0000_55AA);

        // Conflict: 0x1000 and 0x1040 share a line.
        fill("cf_fill1", 32'h1040, 32'hCAFE_F00D);
        load_hit("cf_hit1", 32'h1040, 32'hCAFE_F00D);
        fill("cf_fill0", 32'h1000, 32'h1234_5678);
        load_hit("cf_hit0", 32'h1000, 32'h1234_5678);
        fill("cf_refill1", 32'h1040, 32'hCAFE_F00D);

        // Reset in the middle of a fill.
        drive(1'b1, 1'b0, 32'h3000, 32'h0);
        cyc();
        idle();
        chk("rf_req", {31'h0, mem_req}, 32'h1);
        rst_n = 1'b0;
        #1;
        chk("rf_out", {30'h0, mem_req, mem_we}, 32'h0);
        chk("rf_addr", mem_addr, 32'h0);
        chk("rf_rdata", d_rd_data, 32'h0);
        cyc();
        rst_n = 1'b1;
        ack(32'h7777_7777);
        chk("rf_late_ack", {31'h0, mem_req}, 32'h0);
        drive(1'b1, 1'b0, 32'h3000, 32'h0);
        chk("rf_not_inst", {31'h0, d_miss}, 32'h1);
        idle();
        drive(1'b1, 1'b0, 32'h1040, 32'h0);
        chk("rf_flushed", {31'h0, d_miss}, 32'h1);
        idle();
        #1;
        cyc();
        chk("rf_idle", {31'h0, mem_req}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
